// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction word encoder streaming words to sequential addresses
// Optional INSTR_ENC_IMM_TRUNC_EN: emit out-of-range immediates truncated instead of dropping them.
module instr_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                ERR_W     = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [2:0]        i_in_fmt,
   input  logic [6:0]        i_in_opcode,
   input  logic [4:0]        i_in_rd,
   input  logic [4:0]        i_in_rs1,
   input  logic [4:0]        i_in_rs2,
   input  logic [2:0]        i_in_funct3,
   input  logic [6:0]        i_in_funct7,
   input  logic [31:0]       i_in_imm,
   input  logic              i_in_last,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [31:0]       o_out_instr,
   output logic [ADDR_W-1:0] o_out_addr,
   output logic              o_done,
   output logic              o_err,
   output logic [ERR_W-1:0]  o_err_cnt
);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_ISH = 3'd2;
   localparam logic [2:0] FMT_S   = 3'd3;
   localparam logic [2:0] FMT_B   = 3'd4;
   localparam logic [2:0] FMT_U   = 3'd5;
   localparam logic [2:0] FMT_J   = 3'd6;
   localparam logic [2:0] FMT_RSV = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_out_valid;
   logic [31:0]        r_out_instr;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_done;
   logic               r_err;
   logic [ERR_W-1:0]   r_err_cnt;
   logic               r_last_seen;

   logic [31:0]        w_instr;
   logic               w_viol;
   logic               w_emit_bad;
   logic               w_emit;
   logic               w_in_ready;
   logic               w_accept;
   logic               w_hshake;
   logic               w_sx11;
   logic               w_sx12;
   logic               w_sx20;

   // An immediate fits an N-bit signed field when all bits above it equal its sign bit.
   assign w_sx11 = (&i_in_imm[31:11]) || ~(|i_in_imm[31:11]);
   assign w_sx12 = (&i_in_imm[31:12]) || ~(|i_in_imm[31:12]);
   assign w_sx20 = (&i_in_imm[31:20]) || ~(|i_in_imm[31:20]);

   always_comb begin
      w_instr = '0;
      w_viol  = 1'b0;
      case (i_in_fmt)
         FMT_R: begin
            w_instr = {i_in_funct7, i_in_rs2, i_in_rs1, i_in_funct3, i_in_rd, i_in_opcode};
         end
         FMT_I: begin
            w_instr = {i_in_imm[11:0], i_in_rs1, i_in_funct3, i_in_rd, i_in_opcode};
            w_viol  = !w_sx11;
         end
         FMT_ISH: begin
            w_instr = {i_in_funct7, i_in_imm[4:0], i_in_rs1, i_in_funct3, i_in_rd, i_in_opcode};
            w_viol  = |i_in_imm[31:5];
         end
         FMT_S: begin
            w_instr = {i_in_imm[11:5], i_in_rs2, i_in_rs1, i_in_funct3, i_in_imm[4:0], i_in_opcode};
            w_viol  = !w_sx11;
         end
         FMT_B: begin
            w_instr = {i_in_imm[12], i_in_imm[10:5], i_in_rs2, i_in_rs1, i_in_funct3,
                       i_in_imm[4:1], i_in_imm[11], i_in_opcode};
            w_viol  = !w_sx12 || i_in_imm[0];
         end
         FMT_U: begin
            w_instr = {i_in_imm[31:12], i_in_rd, i_in_opcode};
            w_viol  = |i_in_imm[11:0];
         end
         FMT_J: begin
            w_instr = {i_in_imm[20], i_in_imm[10:1], i_in_imm[11], i_in_imm[19:12],
                       i_in_rd, i_in_opcode};
            w_viol  = !w_sx20 || i_in_imm[0];
         end
         default: begin
            w_viol  = 1'b1;
         end
      endcase
   end

`ifdef INSTR_ENC_IMM_TRUNC_EN
   assign w_emit_bad = (i_in_fmt != FMT_RSV);
`else
   assign w_emit_bad = 1'b0;
`endif

   assign w_emit     = w_viol ? w_emit_bad : 1'b1;
   assign w_in_ready = (r_state == ST_BUSY) && (!r_out_valid || i_out_ready) && !r_last_seen;
   assign w_accept   = i_in_valid && w_in_ready;
   assign w_hshake   = r_out_valid && i_out_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_addr      <= BASE_ADDR;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_err_cnt   <= '0;
         r_last_seen <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state     <= ST_BUSY;
                  r_addr      <= BASE_ADDR;
                  r_err       <= 1'b0;
                  r_err_cnt   <= '0;
                  r_last_seen <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (w_hshake) begin
                  r_out_valid <= 1'b0;
                  r_addr      <= r_addr + ADDR_W'(4);
               end
               if (w_accept) begin
                  if (w_emit) begin
                     r_out_valid <= 1'b1;
                     r_out_instr <= w_instr;
                  end
                  if (w_viol) begin
                     r_err <= 1'b1;
                     if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + ERR_W'(1);
                     end
                  end
                  if (i_in_last) begin
                     r_last_seen <= 1'b1;
                  end
               end
               // Program ends once the last bundle has left the output register or was dropped.
               if (r_last_seen && (!r_out_valid || i_out_ready)) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state     <= ST_IDLE;
               r_last_seen <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_instr = r_out_instr;
   assign o_out_addr  = r_addr;
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_err_cnt   = r_err_cnt;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Assembles RISC-V RV32I instruction words from decoded fields (opcode, registers, funct3/funct7, full-width immediate) and streams them with sequential addresses into instruction memory. Used by the boot/test-program loader in the unpipelined processor. It is the encode direction of the immediate-field layouts the core's decoder extracts. It range-checks every immediate and reports violations.

Parameters:
ADDR_W, 32, width of the output word address.
BASE_ADDR, 32'h0000_0000, first address emitted after start; must be 4-byte aligned.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin a program; sampled only in IDLE.
in_valid  input  1  field bundle valid.
in_ready  output  1  encoder accepts a bundle this cycle.
in_fmt  input  3  0=R, 1=I, 2=I-shift, 3=S, 4=B, 5=U, 6=J, 7=reserved.
in_opcode  input  7  opcode bits [6:0].
in_rd, in_rs1, in_rs2  input  5 each  register indices.
in_funct3  input  3  funct3.
in_funct7  input  7  funct7 (R and I-shift only).
in_imm  input  32  signed byte-offset/value immediate.
in_last  input  1  bundle is the final instruction of the program.
out_valid  output  1  out_instr/out_addr valid.
out_ready  input  1  memory accepts the word.
out_instr  output  32  encoded instruction.
out_addr  output  ADDR_W  byte address of out_instr.
done  output  1  one-cycle pulse when the program completes.
err  output  1  sticky; set on any range violation since start.
err_cnt  output  ERR_W  count of violating bundles, saturating.

Behaviour:
- Reset: state=IDLE, out_valid=0, out_instr=0, out_addr=BASE_ADDR, done=0, err=0, err_cnt=0, in_ready=0. Reset mid-program discards any held word; no done pulse.
- FSM IDLE -> BUSY on start: address counter loaded to BASE_ADDR, err and err_cnt cleared. BUSY -> DONE once the in_last bundle has been emitted, or dropped on error. DONE lasts one cycle with done=1, then returns to IDLE.
- in_ready = (state==BUSY) && (!out_valid || out_ready) && !last_seen. Accept occurs when in_valid && in_ready.
- Latency is 1 cycle: an accepted valid bundle appears registered on out_instr with out_valid=1 the next cycle. out_instr and out_addr are held stable while out_valid && !out_ready.
- Output handshake is out_valid && out_ready. out_addr advances by 4, wrapping modulo 2^ADDR_W. An accept on the same cycle as a handshake is allowed and gives full throughput.
- Encodings, with imm = in_imm:
  - R: f7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]|rs1|f3|rd|op.
  - I-shift: f7|imm[4:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Range rules:
  - I and S: imm in [-2048, 2047].
  - I-shift: imm[31:5]==0.
  - B: imm in [-4096, 4094] and imm[0]==0.
  - J: imm in [-2^20, 2^20-2] and imm[0]==0.
  - U: imm[11:0]==0.
  - fmt 7 always violates.
- On a violation: the bundle is accepted and dropped (no out_valid, address not advanced), err is set, and err_cnt increments, saturating at all-ones. A violating in_last bundle still ends the program (done is pulsed).

Optional Feature:
INSTR_ENC_IMM_TRUNC_EN.
- Defined: a violating bundle (except fmt 7) is emitted with the immediate truncated to the field bits listed above. The address advances, and err/err_cnt still update.
- Undefined: violating bundles are dropped as described in Behaviour.

Test Plan:
- start; I fmt, op=0010011, rd=1, rs1=0, f3=0, imm=5, out_ready=1 -> out_instr=0x00500093 at out_addr=BASE_ADDR one cycle later.
- S op=0100011, f3=010, rs1=1, rs2=2, imm=8 -> 0x0020A423. Next B op=1100011, rs1=rs2=0, imm=-4 -> 0xFE000EE3 at BASE_ADDR+4.
- J op=1101111, rd=1, imm=2048, in_last=1 -> 0x001000EF; done pulses exactly one cycle after the handshake; state returns to IDLE.
- I imm=2048, then B imm=3 -> both dropped; err=1, err_cnt=2, out_addr unchanged. With INSTR_ENC_IMM_TRUNC_EN: both are emitted and the address advances by 8.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0; out_instr/out_addr stable; no bundle lost after out_ready=1.
- Assert rst while out_valid=1 -> next cycle out_valid=0, out_addr=BASE_ADDR, err_cnt=0, no done.
